// File: rtl/stage2_arbiter.sv
// stage2_arbiter: shares one stage2 magnitude/arctangent unit between
// requesters A and B. It grants round-robin, sends a one-cycle start pulse,
// returns the tagged result, and resets stage2 if the result never arrives.
module stage2_arbiter #(
    parameter int TIMEOUT    = 64,  // cycles to wait for s2ValidOut, >= 2
    parameter int RST_CYCLES = 2,   // cycles s2Reset is held high, >= 1
    parameter int TW         = 7    // timer width, 2^TW > max(TIMEOUT, RST_CYCLES)
) (
    input  logic        clock,
    input  logic        reset,

    input  logic        reqA,
    input  logic [13:0] MA,
    input  logic [14:0] NA,
    output logic        ackA,

    input  logic        reqB,
    input  logic [13:0] MB,
    input  logic [14:0] NB,
    output logic        ackB,

    output logic [13:0] s2M,
    output logic [14:0] s2N,
    output logic        s2ValidIn,
    output logic        s2Reset,
    input  logic [15:0] s2MagMN,
    input  logic [12:0] s2Atan,
    input  logic        s2ValidOut,

    output logic [15:0] magOut,
    output logic [12:0] atanOut,
    output logic        tagOut,
    output logic        resValid,
    output logic        timeoutErr,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RECOVER
    } state_t;

    state_t          state;
    logic [TW-1:0]   timer;
    logic            pref_b;   // 1: B wins the next tie
    logic            tag;      // requester of the in-flight transaction
    logic            grant_b;

    // Winner if a grant happens this cycle: a lone requester wins, a tie goes to pref_b.
    assign grant_b = reqB & (~reqA | pref_b);

    // Sequencer: grant, issue, wait for result or timeout, recover stage2.
    // NOTE: every register here, including the operand and result holding
    // registers, is cleared by reset and updated with <= so all of them see
    // the same pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            timer      <= '0;
            pref_b     <= 1'b0;
            tag        <= 1'b0;
            s2M        <= '0;
            s2N        <= '0;
            s2ValidIn  <= 1'b0;
            s2Reset    <= 1'b0;
            ackA       <= 1'b0;
            ackB       <= 1'b0;
            magOut     <= '0;
            atanOut    <= '0;
            tagOut     <= 1'b0;
            resValid   <= 1'b0;
            timeoutErr <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Pulse outputs default low; the state that needs them raises them.
            ackA       <= 1'b0;
            ackB       <= 1'b0;
            s2ValidIn  <= 1'b0;
            resValid   <= 1'b0;
            timeoutErr <= 1'b0;

            case (state)
                IDLE: begin
                    if (reqA || reqB) begin
                        s2M       <= grant_b ? MB : MA;
                        s2N       <= grant_b ? NB : NA;
                        tag       <= grant_b;
                        pref_b    <= ~grant_b;
                        ackA      <= ~grant_b;
                        ackB      <= grant_b;
                        s2ValidIn <= 1'b1;
                        busy      <= 1'b1;
                        state     <= ISSUE;
                    end
                end

                ISSUE: begin
                    timer <= TW'(TIMEOUT);
                    state <= WAIT;
                end

                WAIT: begin
                    if (s2ValidOut) begin
                        magOut   <= s2MagMN;
                        atanOut  <= s2Atan;
                        tagOut   <= tag;
                        resValid <= 1'b1;
                        busy     <= 1'b0;
                        state    <= IDLE;
                    end else if (timer == TW'(1)) begin
                        // Last wait cycle without a result: drop the request.
                        timeoutErr <= 1'b1;
                        tagOut     <= tag;
                        s2Reset    <= 1'b1;
                        timer      <= TW'(RST_CYCLES);
                        state      <= RECOVER;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                RECOVER: begin
                    if (timer == TW'(1)) begin
                        s2Reset <= 1'b0;
                        busy    <= 1'b0;
                        state   <= IDLE;
                    end else begin
                        timer <= timer - TW'(1);
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stage2_arbiter.sv
// tb_stage2_arbiter: randomized and directed transactions against a
// transaction-level reference model of the arbiter and a stage2 model.
module tb_stage2_arbiter;

    localparam int TO = 8;
    localparam int RC = 2;

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        reqA = 1'b0, reqB = 1'b0;
    logic [13:0] MA = '0, MB = '0;
    logic [14:0] NA = '0, NB = '0;
    logic        ackA, ackB;
    logic [13:0] s2M;
    logic [14:0] s2N;
    logic        s2ValidIn, s2Reset;
    logic [15:0] s2MagMN = '0;
    logic [12:0] s2Atan = '0;
    logic        s2ValidOut = 1'b0;
    logic [15:0] magOut;
    logic [12:0] atanOut;
    logic        tagOut, resValid, timeoutErr, busy;

    int total = 0;
    int bad   = 0;
    bit pref_b = 1'b0;   // model: 1 means B wins the next tie

    stage2_arbiter #(.TIMEOUT(TO), .RST_CYCLES(RC), .TW(4)) dut (
        .clock(clock), .reset(reset),
        .reqA(reqA), .MA(MA), .NA(NA), .ackA(ackA),
        .reqB(reqB), .MB(MB), .NB(NB), .ackB(ackB),
        .s2M(s2M), .s2N(s2N), .s2ValidIn(s2ValidIn), .s2Reset(s2Reset),
        .s2MagMN(s2MagMN), .s2Atan(s2Atan), .s2ValidOut(s2ValidOut),
        .magOut(magOut), .atanOut(atanOut), .tagOut(tagOut),
        .resValid(resValid), .timeoutErr(timeoutErr), .busy(busy)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_busy"}, busy, 0);
        check({tag, "_s2M"}, s2M, 0);
        check({tag, "_s2N"}, s2N, 0);
        check({tag, "_vin"}, s2ValidIn, 0);
        check({tag, "_s2rst"}, s2Reset, 0);
        check({tag, "_acks"}, {ackA, ackB}, 0);
        check({tag, "_res"}, {resValid, timeoutErr, tagOut}, 0);
        check({tag, "_mag"}, magOut, 0);
        check({tag, "_atan"}, atanOut, 0);
    endtask

    // Called at a falling edge; leaves the bench at a falling edge.
    task automatic do_reset();
        reset = 1'b1;
        reqA = 1'b0;
        reqB = 1'b0;
        s2ValidOut = 1'b0;
        pref_b = 1'b0;
        @(negedge clock);
        check_all_zero("rst");
        reset = 1'b0;
    endtask

    // Idle cycles with no requests; optionally a spurious strobe in the first one.
    task automatic idle(input int n, input bit spur);
        for (int i = 0; i < n; i++) begin
            reqA = 1'b0;
            reqB = 1'b0;
            s2ValidOut = spur && (i == 0);
            @(negedge clock);
            check("idle_busy", busy, 0);
            check("idle_res", {resValid, timeoutErr}, 0);
            check("idle_vin", s2ValidIn, 0);
        end
        s2ValidOut = 1'b0;
    endtask

    // One arbitration. Cycle 0 is the cycle whose closing edge sees the request;
    // stage2 answers lat cycles after its start pulse (lat=0: never).
    task automatic run_txn(input bit ra, input bit rb, input bit hold, input int lat,
                           input bit spur, input logic [13:0] ma, input logic [14:0] na,
                           input logic [13:0] mb, input logic [14:0] nb,
                           input logic [15:0] mag, input logic [12:0] ang);
        bit win_b, succ;
        int done, wait_end;
        win_b    = rb && (!ra || pref_b);
        pref_b   = !win_b;
        succ     = (lat >= 1) && (lat <= TO);
        done     = succ ? lat + 2 : TO + 2 + RC;   // first cycle back in IDLE
        wait_end = succ ? lat + 1 : TO + 1;
        reqA = ra; reqB = rb;
        MA = ma; NA = na; MB = mb; NB = nb;
        s2ValidOut = 1'b0;
        for (int c = 1; c <= done; c++) begin
            @(negedge clock);
            check("ackA", ackA, (c == 1) && !win_b);
            check("ackB", ackB, (c == 1) && win_b);
            check("s2ValidIn", s2ValidIn, c == 1);
            check("busy", busy, c < done);
            check("resValid", resValid, succ && (c == done));
            check("timeoutErr", timeoutErr, !succ && (c == TO + 2));
            check("s2Reset", s2Reset, !succ && (c >= TO + 2) && (c <= TO + 1 + RC));
            if (c <= wait_end) begin
                check("s2M", s2M, win_b ? mb : ma);
                check("s2N", s2N, win_b ? nb : na);
            end
            if (succ && c == done) begin
                check("magOut", magOut, mag);
                check("atanOut", atanOut, ang);
                check("tag_res", tagOut, win_b);
            end
            if (!succ && c == TO + 2)
                check("tag_err", tagOut, win_b);
            // Drive inputs for this cycle.
            if (c == 1) begin
                if (!hold) begin
                    reqA = 1'b0;
                    reqB = 1'b0;
                end
                MA = 14'($urandom); NA = 15'($urandom);
                MB = 14'($urandom); NB = 15'($urandom);
            end
            s2ValidOut = ((lat > 0) && (c == lat + 1)) ||
                         (spur && ((c == 1) || (!succ && c == TO + 2)));
            if ((lat > 0) && (c == lat + 1)) begin
                s2MagMN = mag;
                s2Atan  = ang;
            end else begin
                s2MagMN = 16'($urandom);
                s2Atan  = 13'($urandom);
            end
        end
        s2ValidOut = 1'b0;
    endtask

    initial begin
        @(negedge clock);
        do_reset();

        // Single request with latency-4 stage2.
        run_txn(1, 0, 0, 4, 0, 14'd5850, 15'(-1700), 14'd0, 15'd0, 16'd6092, 13'(-371));
        idle(2, 0);

        // Contention after reset, both held: A, B, A, B.
        do_reset();
        for (int i = 0; i < 4; i++)
            run_txn(1, 1, 1, $urandom_range(1, TO), 0, 14'($urandom), 15'($urandom),
                    14'($urandom), 15'($urandom), 16'($urandom), 13'($urandom));
        idle(2, 0);

        // Timeout, expiry-cycle boundary, spurious strobes in IDLE/ISSUE/RECOVER.
        run_txn(1, 0, 0, 0, 0, 14'd100, 15'd200, 14'd0, 15'd0, 16'd0, 13'd0);
        run_txn(0, 1, 0, TO, 0, 14'd0, 15'd0, 14'd16383, 15'h4000, 16'hffff, 13'h1000);
        idle(3, 1);
        run_txn(1, 1, 0, 0, 1, 14'd7, 15'd8, 14'd9, 15'd10, 16'd0, 13'd0);
        run_txn(1, 0, 0, TO + 1, 0, 14'd11, 15'd12, 14'd0, 15'd0, 16'd5, 13'd6);
        idle(1, 1);

        // Asynchronous reset in WAIT, then a fresh B request.
        reqA = 1'b1; MA = 14'd1234; NA = 15'd4321;
        @(negedge clock);
        reqA = 1'b0;
        @(negedge clock);
        @(negedge clock);
        check("pre_rst_busy", busy, 1);
        #2 reset = 1'b1;
        #1 check_all_zero("async_rst");
        pref_b = 1'b0;
        @(negedge clock);
        check_all_zero("rst_hold");
        reset = 1'b0;
        run_txn(0, 1, 0, 3, 0, 14'd0, 15'd0, 14'd222, 15'd333, 16'd444, 13'd555);

        // Randomized traffic.
        for (int i = 0; i < 60; i++) begin
            bit ra, rb;
            int lat;
            idle($urandom_range(0, 3), 1'($urandom));
            ra = 1'($urandom);
            rb = 1'($urandom);
            if (!ra && !rb) ra = 1'b1;
            lat = ($urandom_range(0, 3) == 0) ? $urandom_range(0, TO + RC)
                                              : $urandom_range(1, TO);
            run_txn(ra, rb, 0, lat, 1'($urandom), 14'($urandom), 15'($urandom),
                    14'($urandom), 15'($urandom), 16'($urandom), 13'($urandom));
        end
        idle(2, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
